// File: rtl/seq_mul.sv
// Sequential unsigned shift-and-add multiplier with a start/busy/done handshake.
// The design adds one masked partial product per cycle and has a fixed latency of WIDTH+1 edges.
module seq_mul #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   p
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   p_q, p_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [PW-1:0]   partial_s;
   logic [PW-1:0]   step_sum_s;

   // one AND row of the array, then the running sum including it
   assign partial_s  = mcand_q & {PW{mplier_q[0]}};
   assign step_sum_s = acc_q + partial_s;

   // next-state, datapath and registered-output decode
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      p_d      = p_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, a};
               mplier_d = b;
               acc_d    = {PW{1'b0}};
               cnt_d    = {CW{1'b0}};
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d    = step_sum_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_LAST) begin
               p_d     = step_sum_s;
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mcand_q  <= {PW{1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         acc_q    <= {PW{1'b0}};
         cnt_q    <= {CW{1'b0}};
         p_q      <= {PW{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign p    = p_q;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul: a cycle-level behavioural model compared every cycle,
// plus directed literal checks and randomized operand pairs.
module tb_seq_mul;

   localparam int WIDTH = 8;
   localparam int PW    = 2 * WIDTH;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [PW-1:0]    p;

   int checks;
   int failures;

   // model: edges remaining until the operation returns to idle, pending product, visible p
   int            m_left;
   logic [PW-1:0] m_prod;
   logic [PW-1:0] m_p;

   seq_mul #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: accept when idle, product appears WIDTH edges later with done
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left <= 0;
         m_prod <= '0;
         m_p    <= '0;
      end else if (m_left == 0) begin
         if (start) begin
            m_left <= WIDTH + 1;
            m_prod <= PW'(a) * PW'(b);
         end
      end else begin
         m_left <= m_left - 1;
         if (m_left == 2) m_p <= m_prod;
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      check("busy_model", 32'(busy), 32'(m_left > 0));
      check("done_model", 32'(done), 32'(m_left == 1));
      check("p_model", 32'(p), 32'(m_p));
   end

   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic [PW-1:0] exp_p);
      int n;
      @(negedge clk);
      a = ta; b = tb_v; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      check("busy_after_accept", 32'(busy), 32'd1);
      while (!done && n < 40) begin
         @(negedge clk);
         n = n + 1;
      end
      check("latency", 32'(n), 32'(WIDTH + 1));
      check("product", 32'(p), 32'(exp_p));
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_falls", 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int t;
      int last;
      int pulses;
      int idle_cnt;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      checks = 0; failures = 0;
      start = 1'b0; a = '0; b = '0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_p", 32'(p), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op(8'h0D, 8'h0B, 16'h008F);
      run_op(8'hFF, 8'hFF, 16'hFE01);
      run_op(8'h00, 8'hA5, 16'h0000);
      run_op(8'h80, 8'h80, 16'h4000);

      // operands and start ignored while busy, including the DONE cycle
      @(negedge clk);
      a = 8'h03; b = 8'h05; start = 1'b1;
      @(negedge clk);
      a = 8'hFF; b = 8'hFF;
      n = 1;
      while (!done && n < 40) begin
         @(negedge clk);
         n = n + 1;
      end
      check("ignore_latency", 32'(n), 32'(WIDTH + 1));
      check("ignore_product", 32'(p), 32'h000F);
      @(negedge clk);
      start = 1'b0;
      check("ignore_busy_after_done", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check("ignore_no_second_op", 32'(busy), 32'd0);
      check("ignore_p_held", 32'(p), 32'h000F);

      // start held continuously: back-to-back operations
      @(negedge clk);
      a = 8'h02; b = 8'h03; start = 1'b1;
      t = 0; last = -1; pulses = 0; idle_cnt = 0;
      while (pulses < 3 && t < 100) begin
         @(negedge clk);
         t = t + 1;
         if (done) begin
            check("b2b_product", 32'(p), 32'h0006);
            if (last >= 0) check("b2b_spacing", 32'(t - last), 32'd10);
            last = t;
            pulses = pulses + 1;
            if (pulses == 3) start = 1'b0;
         end else if (pulses == 1 && !busy) begin
            idle_cnt = idle_cnt + 1;
         end
      end
      check("b2b_pulses", 32'(pulses), 32'd3);
      check("b2b_idle_gap", 32'(idle_cnt), 32'd1);
      start = 1'b0;
      @(negedge clk);
      check("b2b_stop", 32'(busy), 32'd0);

      // asynchronous reset in the middle of a run
      @(negedge clk);
      a = 8'h12; b = 8'h34; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_p", 32'(p), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) n = n + 1;
      end
      check("midrst_no_done", 32'(n), 32'd0);
      run_op(8'h12, 8'h34, 16'h03A8);

      // result held through the next operation until its completion
      run_op(8'h07, 8'h06, 16'h002A);
      @(negedge clk);
      a = 8'h10; b = 8'h10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 40) begin
         check("hold_p", 32'(p), 32'h002A);
         @(negedge clk);
         n = n + 1;
      end
      check("hold_latency", 32'(n), 32'(WIDTH + 1));
      check("hold_new_p", 32'(p), 32'h0100);
      @(negedge clk);

      // randomized operands
      for (int i = 0; i < 25; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         run_op(ra, rb, PW'(ra) * PW'(rb));
      end

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
